aes_tx_seq: RTL and testbench
=============================

AES_TX_SEQ -- requirements
Module: aes_tx_seq

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock, rising edge); reset in 1 (asynchronous, active-high).
REQ-002 SHALL have block-side ports:
- blk_valid in 1: 128-bit block offered.
- blk_data in 128: block contents.
- blk_ready out 1: sequencer can accept a block.
- blk_done out 1: one-cycle pulse, last byte handed to UART.
REQ-003 SHALL have PISO-side ports:
- piso_data out 128: registered block for PISO parallel_in.
- piso_load out 1: PISO load strobe.
- piso_hold out 1: 1 = freeze, 0 = shift one byte.
- piso_byte in 8: PISO serial_out.
- piso_empty in 1: PISO drained.
REQ-004 SHALL have UART-side and status ports:
- tx_data out 8: byte to transmit.
- tx_start out 1: one-cycle start strobe.
- tx_busy in 1: UART transmitting, asserted the cycle after tx_start.
- err_underrun out 1: sticky error flag.

Function
REQ-005 SHALL implement states IDLE, LOAD, SEND, ADV, WAIT, DONE, plus SYNC when TX_SYNC_EN is defined.
REQ-006 IDLE:
- blk_ready=1 when err_underrun=0.
- On blk_valid&blk_ready, SHALL register blk_data into piso_data and go to LOAD (or SYNC if enabled).
REQ-007 LOAD SHALL assert piso_load for exactly one cycle, clear the 5-bit byte counter, and go to SEND.
REQ-008 SEND:
- Stays while tx_busy=1.
- When tx_busy=0, asserts tx_start for one cycle with tx_data=piso_byte, increments the counter, and goes to ADV.
REQ-009 ADV SHALL drive piso_hold=0 for exactly one cycle; piso_hold SHALL be 1 in every other state.
REQ-010 WAIT SHALL:
- remain until tx_busy=0;
- then go to DONE if counter==16, else to SEND.
REQ-011 DONE SHALL pulse blk_done for one cycle and return to IDLE; the minimum gap from handshake to next blk_ready is the full 16-byte transmission.
REQ-012 Byte order SHALL be most-significant byte (blk_data[127:120]) first, as presented by the PISO.
REQ-013 If piso_empty=1 in SEND with counter<16, SHALL:
- set err_underrun;
- suppress tx_start;
- return to IDLE.
err_underrun SHALL hold blk_ready=0 until reset.
REQ-014 blk_valid while blk_ready=0 SHALL be ignored; blk_data SHALL be sampled only at the handshake cycle.
REQ-015 tx_start and piso_load SHALL never be asserted in the same cycle.

Reset
REQ-016 reset SHALL asynchronously force:
- state=IDLE, counter=0;
- piso_data=0, tx_data=0;
- piso_load=0, tx_start=0, blk_done=0, err_underrun=0;
- piso_hold=1, blk_ready=0 while reset asserted.
REQ-017 reset mid-block SHALL abort without further tx_start or blk_done; blk_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-018 Macro AES_TX_SYNC_EN.
- Defined: SYNC state sits between IDLE and LOAD, waits for tx_busy=0, then sends header byte 8'hA5 via one tx_start and one WAIT cycle set; a block takes 17 UART bytes.
- Undefined: no SYNC state and no header; IDLE goes directly to LOAD.

Structure
REQ-019 Shared package aes_uart_pkg SHALL hold:
- state enum;
- BLK_BYTES=16;
- SYNC_BYTE=8'hA5.
REQ-020 SHALL be a single flat module; the PISO and UART TX SHALL be external instances. No sub-module is needed.

Verification
REQ-021 Single block: blk_data=128'hFEDCBA9876543210_FEDCBA9876543210, UART model busy 10 cycles per byte -> tx_data sequence FE,DC,BA,98,76,54,32,10 repeated twice, one blk_done, err_underrun=0.
REQ-022 Back-to-back: blk_valid held high with two blocks -> second handshake only after first blk_done; 32 tx_start total, no overlap.
REQ-023 Underrun: PISO model raises piso_empty after byte 4 -> exactly 4 tx_start pulses, err_underrun=1, blk_ready stays 0 until reset.
REQ-024 Reset after byte 7 -> no tx_start/blk_done after reset edge; new block 128'h0123...CDEF transmits 01 first.
REQ-025 AES_TX_SYNC_EN defined -> first tx_data=A5, then 16 block bytes, 17 tx_start per block.
REQ-026 tx_busy held 1 for 100 cycles at SEND -> no tx_start and piso_hold=1 throughout; resumes correctly on release.

Source files
------------

// File: rtl/aes_uart_pkg.sv
`default_nettype none
// ============================================================================
// aes_uart_pkg : shared state encoding and constants for the AES UART sender.
// Revision: 1.0
// ============================================================================
package aes_uart_pkg;

  localparam int         BLK_BYTES = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_ADV  = 3'd3,
    ST_WAIT = 3'd4,
`ifdef AES_TX_SYNC_EN
    ST_DONE = 3'd5,
    ST_SYNC = 3'd6
`else
    ST_DONE = 3'd5
`endif
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aes_tx_seq.sv
`default_nettype none
// ============================================================================
// aes_tx_seq : sequences a 128-bit block through an external PISO into a UART,
// MSB byte first. Optional header byte when AES_TX_SYNC_EN is defined.
// Revision: 1.0
// ============================================================================
module aes_tx_seq
  import aes_uart_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  output logic         blk_ready,
  output logic         blk_done,
  output logic [127:0] piso_data,
  output logic         piso_load,
  output logic         piso_hold,
  input  logic [7:0]   piso_byte,
  input  logic         piso_empty,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_busy,
  output logic         err_underrun
);

  localparam logic [4:0] CNT_FULL = 5'(BLK_BYTES);

  state_t     state;
  logic [4:0] byte_cnt;
`ifdef AES_TX_SYNC_EN
  logic       hdr_pending;
`endif

  // Ready is decoded from state so it can rise in the very first cycle after reset.
  assign blk_ready = (state == ST_IDLE) && !err_underrun && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      byte_cnt     <= '0;
      piso_data    <= '0;
      tx_data      <= '0;
      piso_load    <= 1'b0;
      tx_start     <= 1'b0;
      blk_done     <= 1'b0;
      err_underrun <= 1'b0;
      piso_hold    <= 1'b1;
`ifdef AES_TX_SYNC_EN
      hdr_pending  <= 1'b0;
`endif
    end else begin
      piso_load <= 1'b0;
      tx_start  <= 1'b0;
      blk_done  <= 1'b0;
      piso_hold <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (blk_valid && !err_underrun) begin
            piso_data <= blk_data;
`ifdef AES_TX_SYNC_EN
            state     <= ST_SYNC;
`else
            piso_load <= 1'b1;
            state     <= ST_LOAD;
`endif
          end
        end
`ifdef AES_TX_SYNC_EN
        ST_SYNC: begin
          // Second SYNC cycle carries the header strobe; the UART busy shows up in WAIT.
          if (hdr_pending) begin
            state <= ST_WAIT;
          end else if (!tx_busy) begin
            tx_start    <= 1'b1;
            tx_data     <= SYNC_BYTE;
            hdr_pending <= 1'b1;
          end
        end
`endif
        ST_LOAD: begin
          byte_cnt <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (piso_empty && (byte_cnt < CNT_FULL)) begin
            err_underrun <= 1'b1;
            state        <= ST_IDLE;
          end else if (!tx_busy) begin
            tx_start  <= 1'b1;
            tx_data   <= piso_byte;
            byte_cnt  <= byte_cnt + 5'd1;
            piso_hold <= 1'b0;
            state     <= ST_ADV;
          end
        end
        ST_ADV: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!tx_busy) begin
`ifdef AES_TX_SYNC_EN
            if (hdr_pending) begin
              hdr_pending <= 1'b0;
              piso_load   <= 1'b1;
              state       <= ST_LOAD;
            end else
`endif
            if (byte_cnt == CNT_FULL) begin
              blk_done <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_SEND;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_tx_seq.sv
`default_nettype none
// ============================================================================
// tb_aes_tx_seq : directed bench with PISO/UART models and a byte scoreboard.
// Revision: 1.0
// ============================================================================
module tb_aes_tx_seq;
  import aes_uart_pkg::*;

`ifdef AES_TX_SYNC_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BPB = 16 + HDR;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_ready, blk_done;
  logic [127:0] piso_data;
  logic         piso_load, piso_hold;
  logic [7:0]   piso_byte;
  logic         piso_empty;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic         err_underrun;

  always #5 clk = ~clk;

  aes_tx_seq u_dut (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready), .blk_done(blk_done),
    .piso_data(piso_data), .piso_load(piso_load), .piso_hold(piso_hold),
    .piso_byte(piso_byte), .piso_empty(piso_empty),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .err_underrun(err_underrun)
  );

  // PISO model: loads 16 bytes, presents the top byte, shifts when hold is low.
  logic [127:0] p_sr = '0;
  int           p_left = 0;
  bit           underrun_mode = 1'b0;
  always @(posedge clk) begin
    if (piso_load) begin
      p_sr   <= piso_data;
      p_left <= 16;
    end else if (!piso_hold && p_left > 0) begin
      p_sr   <= {p_sr[119:0], 8'h00};
      p_left <= p_left - 1;
    end
  end
  assign piso_byte  = p_sr[127:120];
  assign piso_empty = underrun_mode ? (p_left <= 12) : (p_left == 0);

  // UART model: busy for 10 cycles starting the cycle after tx_start.
  int u_cnt = 0;
  bit force_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start)       u_cnt <= 10;
    else if (u_cnt > 0) u_cnt <= u_cnt - 1;
  end
  assign tx_busy = force_busy || (u_cnt > 0);

  int         checks = 0, errors = 0;
  int         hs_cnt = 0, tx_cnt = 0, done_cnt = 0, shift_in_blk = 0;
  bit         in_block = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        in_block = 1'b0;
      end else begin
        if (blk_valid && blk_ready) begin
          chk("handshake_while_busy", in_block, 1'b0);
`ifdef AES_TX_SYNC_EN
          exp_q.push_back(SYNC_BYTE);
`endif
          for (int i = 15; i >= 0; i--) exp_q.push_back(blk_data[i*8 +: 8]);
          in_block = 1'b1;
          shift_in_blk = 0;
          hs_cnt++;
        end
        if (!piso_hold) shift_in_blk++;
        if (force_busy) begin
          chk("hold_while_busy", piso_hold, 1'b1);
          chk("start_while_busy", tx_start, 1'b0);
        end
        if (tx_start) begin
          tx_cnt++;
          log_q.push_back(tx_data);
          chk("start_with_load", piso_load, 1'b0);
          if (exp_q.size() == 0) begin
            chk("unexpected_start", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", tx_data, e);
          end
        end
        if (blk_done) begin
          done_cnt++;
          chk("done_in_block", in_block, 1'b1);
          chk("done_bytes_left", exp_q.size(), 0);
          chk("done_shift_count", shift_in_blk, 16);
          in_block = 1'b0;
        end
        if (err_underrun) chk("ready_after_err", blk_ready, 1'b0);
      end
    end
  endtask

  function automatic int cur(input int kind);
    case (kind)
      0:       return hs_cnt;
      1:       return tx_cnt;
      2:       return done_cnt;
      default: return int'(err_underrun);
    endcase
  endfunction

  task automatic wait_for(input int kind, input int target, input int budget, input string name);
    int n = 0;
    while (cur(kind) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cur(kind) < target) begin
      errors++;
      $display("FAIL %s: timeout, count %0d expected %0d", name, cur(kind), target);
    end
  endtask

  task automatic send(input logic [127:0] d);
    int h = hs_cnt;
    @(posedge clk); #1;
    blk_data  = d;
    blk_valid = 1'b1;
    wait_for(0, h + 1, 800, "handshake");
    @(posedge clk); #1;
    blk_valid = 1'b0;
    blk_data  = {128{1'b1}};
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  localparam logic [127:0] D_SINGLE = 128'hFEDCBA9876543210_FEDCBA9876543210;
  localparam logic [127:0] D_A      = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D_B      = 128'h8899AABBCCDDEEFF0011223344556677;
  localparam logic [127:0] D_NEW    = 128'h0123456789ABCDEF_0123456789ABCDEF;

  initial begin
    int bt, bd, bl, bh;
    reset = 1'b1; blk_valid = 1'b0; blk_data = '0;
    fork monitor(); join_none
    repeat (3) @(posedge clk); #1;
    chk("rst_blk_ready", blk_ready, 1'b0);
    chk("rst_piso_hold", piso_hold, 1'b1);
    chk("rst_piso_load", piso_load, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_blk_done", blk_done, 1'b0);
    chk("rst_err", err_underrun, 1'b0);
    chk("rst_piso_data", piso_data, 128'h0);
    chk("rst_tx_data", tx_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_release", blk_ready, 1'b1);

    // single block
    bt = tx_cnt; bd = done_cnt; bl = log_q.size();
    send(D_SINGLE);
    wait_for(2, bd + 1, 600, "single_done");
    chk("single_tx_count", tx_cnt - bt, BPB);
`ifdef AES_TX_SYNC_EN
    chk("single_header", log_q[bl], 8'hA5);
`endif
    chk("single_byte0", log_q[bl + HDR], 8'hFE);
    chk("single_byte1", log_q[bl + HDR + 1], 8'hDC);
    chk("single_byte7", log_q[bl + HDR + 7], 8'h10);
    chk("single_byte8", log_q[bl + HDR + 8], 8'hFE);
    chk("single_byte15", log_q[bl + HDR + 15], 8'h10);
    chk("single_done_count", done_cnt - bd, 1);
    chk("single_err", err_underrun, 1'b0);

    // back-to-back with valid held high
    bt = tx_cnt; bd = done_cnt; bl = log_q.size(); bh = hs_cnt;
    @(posedge clk); #1;
    blk_data = D_A; blk_valid = 1'b1;
    wait_for(0, bh + 1, 800, "b2b_hs1");
    @(posedge clk); #1;
    blk_data = D_B;
    wait_for(0, bh + 2, 800, "b2b_hs2");
    @(posedge clk); #1;
    blk_valid = 1'b0;
    wait_for(2, bd + 2, 800, "b2b_done");
    chk("b2b_tx_count", tx_cnt - bt, 2 * BPB);
    chk("b2b_first_a", log_q[bl + HDR], 8'h00);
    chk("b2b_first_b", log_q[bl + BPB + HDR], 8'h88);

    // UART held busy for 100 cycles
    bt = tx_cnt; bd = done_cnt;
    force_busy = 1'b1;
    send(D_A);
    repeat (100) @(negedge clk);
    chk("stall_no_start", tx_cnt - bt, 0);
    @(posedge clk); #1;
    force_busy = 1'b0;
    wait_for(2, bd + 1, 600, "stall_done");
    chk("stall_tx_count", tx_cnt - bt, BPB);

    // PISO underrun after 4 bytes
    bt = tx_cnt; bd = done_cnt; bh = hs_cnt;
    underrun_mode = 1'b1;
    send(D_B);
    wait_for(3, 1, 600, "underrun_flag");
    @(posedge clk); #1;
    blk_valid = 1'b1; blk_data = D_A;
    repeat (20) @(negedge clk);
    chk("underrun_tx_count", tx_cnt - bt, 4 + HDR);
    chk("underrun_err", err_underrun, 1'b1);
    chk("underrun_ready", blk_ready, 1'b0);
    chk("underrun_no_hs", hs_cnt - bh, 1);
    chk("underrun_no_done", done_cnt - bd, 0);
    underrun_mode = 1'b0;
    blk_valid = 1'b0;
    pulse_reset();
    @(negedge clk);
    chk("err_cleared", err_underrun, 1'b0);
    chk("ready_after_err_reset", blk_ready, 1'b1);

    // reset after byte 7 of a block
    bt = tx_cnt;
    send(D_B);
    wait_for(1, bt + HDR + 7, 600, "mid_byte7");
    pulse_reset();
    @(negedge clk);
    chk("mid_ready_after_release", blk_ready, 1'b1);
    bt = tx_cnt; bd = done_cnt;
    repeat (40) @(negedge clk);
    chk("mid_no_start", tx_cnt - bt, 0);
    chk("mid_no_done", done_cnt - bd, 0);
    bl = log_q.size();
    send(D_NEW);
    wait_for(2, bd + 1, 600, "new_done");
    chk("new_tx_count", tx_cnt - bt, BPB);
    chk("new_first", log_q[bl + HDR], 8'h01);
    chk("new_last", log_q[bl + HDR + 15], 8'hEF);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 500000", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
